// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared state encoding and defaults for the UART packet controller
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_HOLD    = 3'd5
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
    localparam int         MAX_LEN_DEF   = 16;

    // States in which the inter-byte timeout is armed
    function automatic logic in_frame(input pkt_state_t s);
        return (s == S_CMD) || (s == S_LEN) || (s == S_PAYLOAD) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/uart_pkt_buffer.sv
// rtl/uart_pkt_buffer.sv - payload register file with synchronous write and registered read
module uart_pkt_buffer
    import uart_pkt_pkg::*;
#(
    parameter int DEPTH  = MAX_LEN_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    // Storage is sized to the full address space so every read address is in range
    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    // Payload storage write; contents are deliberately left unreset
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, cleared by reset so the output starts at zero
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - parses UART byte strobes into checksummed command packets
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN      = MAX_LEN_DEF,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 8700,
    parameter int         LEN_W        = $clog2(MAX_LEN + 1),
    parameter int         ADDR_W       = $clog2(MAX_LEN)
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Pkt_Valid,
    input  logic              i_Pkt_Ack,
    output logic [7:0]        o_Cmd,
    output logic [LEN_W-1:0]  o_Len,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Err_Csum,
    output logic              o_Err_Len,
    output logic              o_Err_Timeout,
    output logic              o_Err_Overrun,
    output logic              o_Busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

    pkt_state_t        state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_csum_d, err_len_d, err_tmo_d, err_ovr_d;
    logic              buf_we;
    logic              armed;

    assign armed       = in_frame(state_q);
    assign o_Pkt_Valid = (state_q == S_HOLD);
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Cmd       = cmd_q;
    assign o_Len       = len_q;

    // Next-state, datapath and error-pulse decode; every transition is keyed on a strobe except HOLD exit and timeout
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        csum_d     = csum_q;
        idx_d      = idx_q;
        cnt_d      = (armed && !i_Rx_DV) ? cnt_q + CNT_W'(1) : '0;
        err_csum_d = 1'b0;
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        err_ovr_d  = 1'b0;
        buf_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                    csum_d  = 8'h00;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (i_Rx_DV) begin
                    cmd_d   = i_Rx_Byte;
                    csum_d  = i_Rx_Byte;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = i_Rx_Byte[LEN_W-1:0];
                        csum_d  = csum_q ^ i_Rx_Byte;
                        idx_d   = '0;
                        state_d = (i_Rx_Byte == 8'h00) ? S_CSUM : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ i_Rx_Byte;
                    idx_d  = idx_q + ADDR_W'(1);
                    if (LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == csum_q) begin
                        state_d = S_HOLD;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // A strobe here is dropped but the ack in the same cycle still releases the packet
                err_ovr_d = i_Rx_DV;
                if (i_Pkt_Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Silence for the full window aborts the frame; the count reaches TIMEOUT_CLKS-1 on this edge
        if (armed && !i_Rx_DV && cnt_q == CNT_W'(TIMEOUT_CLKS - 2)) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = '0;
        end
    end

    // State, datapath and error-pulse registers
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q       <= S_IDLE;
            cmd_q         <= 8'h00;
            len_q         <= '0;
            csum_q        <= 8'h00;
            idx_q         <= '0;
            cnt_q         <= '0;
            o_Err_Csum    <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Err_Overrun <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            csum_q        <= csum_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            o_Err_Csum    <= err_csum_d;
            o_Err_Len     <= err_len_d;
            o_Err_Timeout <= err_tmo_d;
            o_Err_Overrun <= err_ovr_d;
        end
    end

    uart_pkt_buffer #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .wr_en     (buf_we),
        .wr_addr   (idx_q),
        .wr_data   (i_Rx_Byte),
        .rd_addr   (i_Rd_Addr),
        .rd_data   (o_Rd_Data)
    );

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb/tb_uart_rx_pkt_ctrl.sv - randomized self-checking bench for uart_rx_pkt_ctrl
module tb_uart_rx_pkt_ctrl;

    localparam int         MAX_LEN      = 16;
    localparam int         LEN_W        = 5;
    localparam int         ADDR_W       = 4;
    localparam int         TIMEOUT_CLKS = 8700;
    localparam logic [7:0] SYNC         = 8'hAA;

    logic              i_Clock = 1'b0;
    logic              i_Reset_n = 1'b0;
    logic              i_Rx_DV = 1'b0;
    logic [7:0]        i_Rx_Byte = 8'h00;
    logic              o_Pkt_Valid;
    logic              i_Pkt_Ack = 1'b0;
    logic [7:0]        o_Cmd;
    logic [LEN_W-1:0]  o_Len;
    logic [ADDR_W-1:0] i_Rd_Addr = '0;
    logic [7:0]        o_Rd_Data;
    logic              o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Err_Overrun, o_Busy;

    uart_rx_pkt_ctrl dut (
        .i_Clock       (i_Clock),
        .i_Reset_n     (i_Reset_n),
        .i_Rx_DV       (i_Rx_DV),
        .i_Rx_Byte     (i_Rx_Byte),
        .o_Pkt_Valid   (o_Pkt_Valid),
        .i_Pkt_Ack     (i_Pkt_Ack),
        .o_Cmd         (o_Cmd),
        .o_Len         (o_Len),
        .i_Rd_Addr     (i_Rd_Addr),
        .o_Rd_Data     (o_Rd_Data),
        .o_Err_Csum    (o_Err_Csum),
        .o_Err_Len     (o_Err_Len),
        .o_Err_Timeout (o_Err_Timeout),
        .o_Err_Overrun (o_Err_Overrun),
        .o_Busy        (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_csum = 0, cnt_len = 0, cnt_tmo = 0, cnt_ovr = 0;

    // Pulse counters sampled mid-cycle; a pulse longer than one cycle counts more than once
    always @(negedge i_Clock) begin
        if (o_Err_Csum)    cnt_csum++;
        if (o_Err_Len)     cnt_len++;
        if (o_Err_Timeout) cnt_tmo++;
        if (o_Err_Overrun) cnt_ovr++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        i_Pkt_Ack = ack;
        tick(1);
        i_Rx_DV   = 1'b0;
        i_Pkt_Ack = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] fr[$], input int max_gap);
        foreach (fr[i]) begin
            send_byte(fr[i], 1'b0);
            if (i != fr.size() - 1 && max_gap > 0) tick($urandom_range(0, max_gap));
        end
    endtask

    task automatic do_ack(input string tag);
        i_Pkt_Ack = 1'b1;
        tick(1);
        i_Pkt_Ack = 1'b0;
        check_eq({tag, "_valid_after_ack"}, o_Pkt_Valid, 0);
        check_eq({tag, "_busy_after_ack"}, o_Busy, 0);
    endtask

    task automatic check_payload(input string tag, input logic [7:0] pl[$]);
        foreach (pl[i]) begin
            i_Rd_Addr = ADDR_W'(i);
            tick(1);
            check_eq($sformatf("%s_rd%0d", tag, i), o_Rd_Data, pl[i]);
        end
    endtask

    // Builds a frame from the packet rules, sends it and checks the outcome; leaves a good packet held
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                             input logic [7:0] pl[$], input bit bad_csum, input int max_gap);
        logic [7:0] fr[$];
        logic [7:0] cs;
        int c0, l0, t0, o0;
        cs = cmd ^ len;
        foreach (pl[i]) cs ^= pl[i];
        if (bad_csum) cs ^= 8'($urandom_range(1, 255));
        fr = {SYNC, cmd, len};
        if (len <= MAX_LEN) begin
            foreach (pl[i]) fr.push_back(pl[i]);
            fr.push_back(cs);
        end
        c0 = cnt_csum; l0 = cnt_len; t0 = cnt_tmo; o0 = cnt_ovr;
        send_seq(fr, max_gap);
        tick(1);
        check_eq({tag, "_err_len"}, cnt_len - l0, (len > MAX_LEN) ? 1 : 0);
        check_eq({tag, "_err_csum"}, cnt_csum - c0, (len <= MAX_LEN && bad_csum) ? 1 : 0);
        check_eq({tag, "_err_other"}, (cnt_tmo - t0) + (cnt_ovr - o0), 0);
        if (len > MAX_LEN || bad_csum) begin
            check_eq({tag, "_valid_err"}, o_Pkt_Valid, 0);
            check_eq({tag, "_busy_err"}, o_Busy, 0);
        end else begin
            check_eq({tag, "_valid"}, o_Pkt_Valid, 1);
            check_eq({tag, "_cmd"}, o_Cmd, cmd);
            check_eq({tag, "_len"}, o_Len, len);
            check_payload(tag, pl);
        end
    endtask

    // Waits for a timeout pulse and returns cycles elapsed since the last strobe edge
    task automatic wait_timeout(output int cycles);
        cycles = 0;
        while (!o_Err_Timeout && cycles < TIMEOUT_CLKS + 10) begin
            tick(1);
            cycles++;
        end
    endtask

    logic [7:0] pl[$];
    logic [7:0] empty_q[$];
    int         cyc, o0;

    initial begin
        // Reset state
        tick(3);
        check_eq("rst_valid", o_Pkt_Valid, 0);
        check_eq("rst_busy", o_Busy, 0);
        check_eq("rst_cmd", o_Cmd, 0);
        check_eq("rst_len", o_Len, 0);
        check_eq("rst_rd", o_Rd_Data, 0);
        check_eq("rst_errs", {o_Err_Csum, o_Err_Len, o_Err_Timeout, o_Err_Overrun}, 0);
        i_Reset_n = 1'b1;
        tick(2);

        // Good frame AA 05 02 11 22 34, valid one cycle after last strobe
        send_seq('{SYNC, 8'h05, 8'h02, 8'h11, 8'h22}, 1);
        check_eq("good_valid_pre", o_Pkt_Valid, 0);
        send_byte(8'h34, 1'b0);
        check_eq("good_valid_latency", o_Pkt_Valid, 1);
        check_eq("good_cmd", o_Cmd, 8'h05);
        check_eq("good_len", o_Len, 2);
        check_payload("good", '{8'h11, 8'h22});
        do_ack("good");

        // Noise then zero-length frame, spaced and back-to-back
        send_seq('{8'h00, 8'hFF}, 2);
        run_frame("zlen", 8'h7F, 8'h00, empty_q, 1'b0, 2);
        do_ack("zlen");
        send_seq('{8'h00, 8'hFF}, 0);
        run_frame("zlen_b2b", 8'h7F, 8'h00, empty_q, 1'b0, 0);
        do_ack("zlen_b2b");

        // Checksum error then recovery frame
        run_frame("csum_bad", 8'h05, 8'h02, '{8'h11, 8'h22}, 1'b1, 1);
        run_frame("csum_recover", 8'h01, 8'h00, empty_q, 1'b0, 1);
        do_ack("csum_recover");

        // Length error and the MAX_LEN boundary
        run_frame("len_17", 8'h01, 8'h11, empty_q, 1'b0, 0);
        pl = {};
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'h00);
        run_frame("len_16", 8'h01, 8'h10, pl, 1'b0, 0);
        do_ack("len_16");

        // Timeout at exactly TIMEOUT_CLKS-1 cycles after the last strobe
        send_seq('{SYNC, 8'h05}, 0);
        wait_timeout(cyc);
        check_eq("tmo_cycles", cyc, TIMEOUT_CLKS - 1);
        tick(1);
        check_eq("tmo_busy", o_Busy, 0);
        // Strobe at TIMEOUT_CLKS-2 restarts the window
        send_seq('{SYNC, 8'h05}, 0);
        tick(TIMEOUT_CLKS - 3);
        o0 = cnt_tmo;
        send_byte(8'h03, 1'b0);
        check_eq("tmo_restart_none", cnt_tmo - o0, 0);
        check_eq("tmo_restart_busy", o_Busy, 1);
        wait_timeout(cyc);
        check_eq("tmo_restart_cycles", cyc, TIMEOUT_CLKS - 1);
        tick(1);

        // Overrun while held, packet contents untouched
        run_frame("ovr", 8'h42, 8'h03, '{8'h10, 8'h20, 8'h30}, 1'b0, 1);
        o0 = cnt_ovr;
        send_byte(SYNC, 1'b0);
        tick(1);
        check_eq("ovr_pulse", cnt_ovr - o0, 1);
        check_eq("ovr_valid", o_Pkt_Valid, 1);
        check_eq("ovr_cmd", o_Cmd, 8'h42);
        check_eq("ovr_len", o_Len, 3);
        check_payload("ovr", '{8'h10, 8'h20, 8'h30});
        do_ack("ovr");

        // Reset mid-payload
        send_seq('{SYNC, 8'h05, 8'h03, 8'h11}, 0);
        #2;
        i_Reset_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", o_Pkt_Valid, 0);
        check_eq("rst_mid_busy", o_Busy, 0);
        check_eq("rst_mid_cmd", o_Cmd, 0);
        check_eq("rst_mid_len", o_Len, 0);
        tick(2);
        i_Reset_n = 1'b1;
        tick(1);
        run_frame("post_rst", 8'h09, 8'h01, '{8'h5A}, 1'b0, 1);
        do_ack("post_rst");

        // Randomized frames against the packet rules
        for (int f = 0; f < 60; f++) begin
            logic [7:0] len, cmd, nz;
            bit bad;
            string tag;
            tag = $sformatf("rnd%0d", f);
            for (int n = $urandom_range(0, 2); n > 0; n--) begin
                nz = 8'($urandom_range(0, 255));
                if (nz == SYNC) nz = 8'h00;
                send_byte(nz, 1'b0);
            end
            cmd = 8'($urandom_range(0, 255));
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(MAX_LEN + 1, 255))
                                              : 8'($urandom_range(0, MAX_LEN));
            bad = ($urandom_range(0, 3) == 0);
            pl = {};
            if (len <= MAX_LEN) for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            run_frame(tag, cmd, len, pl, bad, $urandom_range(0, 3));
            if (len <= MAX_LEN && !bad) begin
                if ($urandom_range(0, 1) == 1) begin
                    o0 = cnt_ovr;
                    send_byte(8'($urandom_range(0, 255)), 1'b1);
                    tick(1);
                    check_eq({tag, "_ovr_ack"}, cnt_ovr - o0, 1);
                    check_eq({tag, "_valid_ovr_ack"}, o_Pkt_Valid, 0);
                end else begin
                    do_ack(tag);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
